// File: rtl/smpl_queue.sv
// smpl_queue: circular sample buffer feeding the FIR core.
// Each sample that arrives is stored. Once a full window of DEPTH samples is
// held, the window is replayed from oldest to newest, one sample per clock,
// with `sequencing` high. One launch yields exactly one FIR output.
//
// Handshake: `wrt_smpl` is a one-cycle strobe that qualifies `smpl_in`. There is
// no back-pressure. The buffer always accepts the sample. A write that arrives
// while a replay is running sets a single pending launch. A second such write
// before that launch is taken sets the sticky `ovr` flag.
module smpl_queue #(
  parameter int DEPTH  = 1021,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] smpl_in,
  output logic        sequencing,
  output logic [15:0] smpl_out,
  output logic        ovr
);

  localparam int                MEM_N    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] DEPTH_C  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_M1 = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;

  // Sample storage. It is not reset, and it has a synchronous read into smpl_out_q.
  logic [15:0] mem_q [MEM_N];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] new_ptr_q, new_ptr_d;   // next write slot
  logic [ADDR_W-1:0] old_ptr_q, old_ptr_d;   // oldest sample in the window
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;     // replay address
  logic [ADDR_W-1:0] cnt_q, cnt_d;           // stored samples, saturates at DEPTH
  logic [ADDR_W-1:0] idx_q, idx_d;           // replay index 0..DEPTH-1
  logic              pend_q, pend_d;         // one launch queued behind the replay
  logic              ovr_q, ovr_d;
  logic              seq_q, seq_d;
  logic [15:0]       smpl_out_q;

  // Store every strobed sample at the write slot. Writes and the replay range
  // never overlap, because DEPTH < 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (wrt_smpl) begin
      mem_q[new_ptr_q] <= smpl_in;
    end
  end

  // Next-state logic. The write bookkeeping comes first, so the launch decision
  // sees the post-write count and the post-write oldest pointer.
  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    seq_d     = 1'b0;

    if (wrt_smpl) begin
      new_ptr_d = new_ptr_q + ONE;
      if (cnt_q == DEPTH_C) begin
        old_ptr_d = old_ptr_q + ONE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    case (state_q)
      IDLE: begin
        seq_d = 1'b0;
        if ((wrt_smpl && (cnt_d == DEPTH_C)) || pend_q) begin
          rd_ptr_d = old_ptr_d;
          idx_d    = '0;
          pend_d   = 1'b0;
          state_d  = SEQ;
        end
      end
      SEQ: begin
        seq_d    = 1'b1;
        rd_ptr_d = rd_ptr_q + ONE;
        idx_d    = idx_q + ONE;
        if (wrt_smpl) begin
          if (pend_q) begin
            ovr_d = 1'b1;
          end else begin
            pend_d = 1'b1;
          end
        end
        if (idx_q == DEPTH_M1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register the control state and the pointers. Reset restarts the fill phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      seq_q     <= seq_d;
    end
  end

  // Replay data register. It loads only while replaying, and it holds its value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_out_q <= '0;
    end else if (state_q == SEQ) begin
      smpl_out_q <= mem_q[rd_ptr_q];
    end
  end

  assign sequencing = seq_q;
  assign smpl_out   = smpl_out_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_smpl_queue.sv
// tb_smpl_queue: directed bench for smpl_queue.
// dut_a uses DEPTH=5 and ADDR_W=3 for the fill, slide/wrap, pending, overrun and
// reset tests. dut_b uses the default parameters for the long ramp window.
module tb_smpl_queue;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, wrt_a, seq_a, ovr_a;
  logic [15:0] smpl_a, smpl_out_a;
  logic        rst_b_n, wrt_b, seq_b, ovr_b;
  logic [15:0] smpl_b, smpl_out_b;

  int checks = 0;
  int errors = 0;
  int hi_b   = 0;

  smpl_queue #(.DEPTH(5), .ADDR_W(3)) dut_a (
    .clk        (clk),
    .rst_n      (rst_a_n),
    .wrt_smpl   (wrt_a),
    .smpl_in    (smpl_a),
    .sequencing (seq_a),
    .smpl_out   (smpl_out_a),
    .ovr        (ovr_a)
  );

  smpl_queue dut_b (
    .clk        (clk),
    .rst_n      (rst_b_n),
    .wrt_smpl   (wrt_b),
    .smpl_in    (smpl_b),
    .sequencing (seq_b),
    .smpl_out   (smpl_out_b),
    .ovr        (ovr_b)
  );

  // Count the cycles where the default-size instance is replaying.
  always @(negedge clk) begin
    if (seq_b === 1'b1) hi_b++;
  end

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers (dut_a) ----------------
  // A one-cycle write strobe. It returns at the negedge after the sampling edge.
  task automatic write_a(input int v);
    @(negedge clk);
    wrt_a  = 1'b1;
    smpl_a = 16'(v);
    @(negedge clk);
    wrt_a  = 1'b0;
  endtask

  // Idle cycles. sequencing must stay low, and smpl_out must hold its value.
  task automatic idle_a(input int n, input int hold);
    repeat (n) begin
      @(negedge clk);
      check("idle_seq", 32'(seq_a), 32'd0);
      check("idle_hold", 32'(smpl_out_a), 32'(hold));
    end
  endtask

  // Drive a write after slot k's check if k matches an injection point.
  task automatic inject_a(input int k, input int k1, input int v1, input int k2, input int v2);
    if (k == k1) begin
      wrt_a = 1'b1; smpl_a = 16'(v1);
    end else if (k == k2) begin
      wrt_a = 1'b1; smpl_a = 16'(v2);
    end else begin
      wrt_a = 1'b0;
    end
  endtask

  // Expect 5 replay cycles carrying first..first+4, then one low cycle.
  // Slots 0..4 follow the replay cycles, and slot 5 follows the low cycle.
  task automatic window_a(input int first, input int k1, input int v1, input int k2, input int v2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("win_seq", 32'(seq_a), 32'd1);
      check("win_data", 32'(smpl_out_a), 32'(first + k));
      inject_a(k, k1, v1, k2, v2);
    end
    @(negedge clk);
    check("win_end", 32'(seq_a), 32'd0);
    check("win_hold", 32'(smpl_out_a), 32'(first + 4));
    inject_a(5, k1, v1, k2, v2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_a_n = 1'b0; wrt_a = 1'b0; smpl_a = '0;
    rst_b_n = 1'b0; wrt_b = 1'b0; smpl_b = '0;
    repeat (3) @(negedge clk);
    check("rst_seq", 32'(seq_a), 32'd0);
    check("rst_out", 32'(smpl_out_a), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Fill phase: no launch before the 5th sample.
    for (int n = 1; n <= 4; n++) begin
      write_a(n);
      idle_a(9, 0);
    end
    write_a(5);
    window_a(1, -1, 0, -1, 0);
    idle_a(1, 5);

    // Sliding window. Pointers wrap past 7 several times.
    for (int n = 6; n <= 20; n++) begin
      write_a(n);
      window_a(n - 4, -1, 0, -1, 0);
      idle_a(1, n);
    end

    // Pending launch: 22 lands mid-window, so 17..21 completes and then 18..22 follows.
    write_a(21);
    window_a(17, 1, 22, -1, 0);
    window_a(18, -1, 0, -1, 0);
    check("pend_ovr", 32'(ovr_a), 32'd0);

    // A write in the IDLE cycle while pend is set gives a single launch that includes it.
    write_a(23);
    window_a(19, 1, 24, 4, 25);
    window_a(21, -1, 0, -1, 0);
    idle_a(3, 25);
    check("idle_pend_ovr", 32'(ovr_a), 32'd0);

    // Overrun: 27 and 28 (28 in the last replay cycle) both land in one window.
    write_a(26);
    window_a(22, 1, 27, 3, 28);
    window_a(24, -1, 0, -1, 0);
    check("ovr_set", 32'(ovr_a), 32'd1);
    write_a(29);
    window_a(25, -1, 0, -1, 0);
    check("ovr_sticky", 32'(ovr_a), 32'd1);

    // Reset during the 2nd replay cycle.
    write_a(30);
    @(negedge clk);
    check("pre_rst_k0", 32'(smpl_out_a), 32'd26);
    @(negedge clk);
    check("pre_rst_k1", 32'(smpl_out_a), 32'd27);
    rst_a_n = 1'b0;
    #1;
    check("async_rst_seq", 32'(seq_a), 32'd0);
    check("async_rst_out", 32'(smpl_out_a), 32'd0);
    check("async_rst_ovr", 32'(ovr_a), 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    for (int n = 41; n <= 44; n++) begin
      write_a(n);
      idle_a(3, 0);
    end
    write_a(45);
    window_a(41, -1, 0, -1, 0);

    // Default size: 1021 back-to-back writes, then one ramp window.
    for (int i = 1; i <= 1021; i++) begin
      @(negedge clk);
      wrt_b  = 1'b1;
      smpl_b = 16'(i);
    end
    @(negedge clk);
    wrt_b = 1'b0;
    check("big_pre_seq", 32'(seq_b), 32'd0);
    check("big_fill_hi", 32'(hi_b), 32'd0);
    for (int k = 0; k < 1021; k++) begin
      @(negedge clk);
      check("big_seq", 32'(seq_b), 32'd1);
      check("big_data", 32'(smpl_out_b), 32'(k + 1));
    end
    @(negedge clk);
    check("big_end", 32'(seq_b), 32'd0);
    repeat (3) @(negedge clk);
    check("big_hi_cycles", 32'(hi_b), 32'd1021);
    check("big_hold", 32'(smpl_out_b), 32'd1021);
    check("big_ovr", 32'(ovr_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
